// File: rtl/timer_mmio_cmp.sv
// MMIO view of the free-running 64-bit microsecond count: tear-free 32-bit reads
// through a high-word snapshot, plus a 64-bit compare with one-shot or periodic reload.
module timer_mmio_cmp #(
    parameter int PERIOD_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] usCount,
    input  logic        sel,
    input  logic        we,
    input  logic        re,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [2:0] {
        REG_COUNT_LO = 3'd0,
        REG_COUNT_HI = 3'd1,
        REG_CMP_LO   = 3'd2,
        REG_CMP_HI   = 3'd3,
        REG_PERIOD   = 3'd4,
        REG_CTRL     = 3'd5,
        REG_STATUS   = 3'd6,
        REG_RSVD     = 3'd7
    } reg_addr_t;

    localparam logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    logic [31:0]         hi_snap;
    logic [63:0]         cmp;
    logic [PERIOD_W-1:0] period;
    logic                en;
    logic                irq_en;
    logic                pending;

    reg_addr_t   reg_sel;
    logic        wr_acc;
    logic        rd_acc;
    logic        hit;
    logic        period_zero;
    logic        sw_cmp_wr;
    logic        sw_ctrl_wr;
    logic        sw_clear;
    logic [63:0] cmp_next_period;
    logic [31:0] rd_val;

    assign reg_sel = reg_addr_t'(addr);

    // A simultaneous read and write is a write; rdata keeps its old value.
    assign wr_acc = sel & we;
    assign rd_acc = sel & re & ~we;

    assign hit             = en & (usCount >= cmp);
    assign period_zero     = (period == '0);
    assign cmp_next_period = cmp + 64'(period);

    assign sw_cmp_wr  = wr_acc & ((reg_sel == REG_CMP_LO) | (reg_sel == REG_CMP_HI));
    assign sw_ctrl_wr = wr_acc & (reg_sel == REG_CTRL);
    assign sw_clear   = wr_acc & (reg_sel == REG_STATUS) & wdata[0];

    assign irq = pending & irq_en;

    // NOTE: every path assigns rd_val a default first so no latch is inferred.
    always_comb begin
        rd_val = '0;
        unique case (reg_sel)
            REG_COUNT_LO: rd_val = usCount[31:0];
            REG_COUNT_HI: rd_val = hi_snap;
            REG_CMP_LO:   rd_val = cmp[31:0];
            REG_CMP_HI:   rd_val = cmp[63:32];
            REG_PERIOD:   rd_val = 32'(period);
            REG_CTRL:     rd_val = {30'd0, irq_en, en};
            REG_STATUS:   rd_val = {31'd0, pending};
            REG_RSVD:     rd_val = '0;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata   <= '0;
            hi_snap <= '0;
            cmp     <= CMP_RESET;
            period  <= '0;
            en      <= 1'b0;
            irq_en  <= 1'b0;
            pending <= 1'b0;
        end else begin
            if (rd_acc) begin
                rdata <= rd_val;
                if (reg_sel == REG_COUNT_LO)
                    hi_snap <= usCount[63:32];
            end

            // Software writes to the compare value win over the periodic reload.
            if (sw_cmp_wr) begin
                if (reg_sel == REG_CMP_LO)
                    cmp[31:0] <= wdata;
                else
                    cmp[63:32] <= wdata;
            end else if (hit && !period_zero) begin
                cmp <= cmp_next_period;
            end

            if (wr_acc && reg_sel == REG_PERIOD)
                period <= PERIOD_W'(wdata);

            if (sw_ctrl_wr) begin
                en     <= wdata[0];
                irq_en <= wdata[1];
            end else if (hit && period_zero) begin
                en <= 1'b0;
            end

            // A new hit outranks a same-cycle write-1-clear.
            if (hit)
                pending <= 1'b1;
            else if (sw_clear)
                pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_timer_mmio_cmp.sv
// Self-checking bench for timer_mmio_cmp: directed scenarios then randomized traffic,
// compared against a transaction-level model of the register map.
module tb_timer_mmio_cmp;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] usCount;
    logic        sel;
    logic        we;
    logic        re;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    timer_mmio_cmp #(.PERIOD_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .usCount (usCount),
        .sel     (sel),
        .we      (we),
        .re      (re),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [63:0] cnt;
    logic [63:0] m_cmp;
    logic [31:0] m_period;
    logic [31:0] m_hi;
    logic [31:0] m_rdata;
    logic        m_en;
    logic        m_irq_en;
    logic        m_pending;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return cnt[31:0];
            3'd1:    return m_hi;
            3'd2:    return m_cmp[31:0];
            3'd3:    return m_cmp[63:32];
            3'd4:    return m_period;
            3'd5:    return {30'd0, m_irq_en, m_en};
            3'd6:    return {31'd0, m_pending};
            default: return 32'd0;
        endcase
    endfunction

    // One clock: drive inputs, advance the model, then compare outputs after the edge.
    task automatic step(input logic r, input logic s, input logic w, input logic rd,
                        input logic [2:0] a, input logic [31:0] d);
        logic        is_hit;
        logic        is_wr;
        logic [63:0] old_cmp;
        logic [31:0] old_period;
        rst = r; sel = s; we = w; re = rd; addr = a; wdata = d; usCount = cnt;
        is_hit     = m_en && (cnt >= m_cmp);
        is_wr      = s && w;
        old_cmp    = m_cmp;
        old_period = m_period;
        if (r) begin
            m_rdata = 0; m_hi = 0; m_cmp = '1; m_period = 0;
            m_en = 0; m_irq_en = 0; m_pending = 0;
        end else begin
            if (s && rd && !w) begin
                m_rdata = model_read(a);
                if (a == 3'd0) m_hi = cnt[63:32];
            end
            if (is_wr && a == 3'd2)      m_cmp[31:0]  = d;
            else if (is_wr && a == 3'd3) m_cmp[63:32] = d;
            else if (is_hit && old_period != 0) m_cmp = old_cmp + {32'd0, old_period};
            if (is_wr && a == 3'd4) m_period = d;
            if (is_wr && a == 3'd5) begin
                m_en = d[0]; m_irq_en = d[1];
            end else if (is_hit && old_period == 0) begin
                m_en = 0;
            end
            if (is_hit) m_pending = 1;
            else if (is_wr && a == 3'd6 && d[0]) m_pending = 0;
        end
        @(posedge clk);
        #1;
        check("rdata", {32'd0, rdata}, {32'd0, m_rdata});
        check("irq", {63'd0, irq}, {63'd0, m_pending & m_irq_en});
        sel = 1'b0; we = 1'b0; re = 1'b0; rst = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd_reg(input logic [2:0] a);
        step(1'b0, 1'b1, 1'b0, 1'b1, a, 32'd0);
    endtask

    int n_rise;
    logic prev_irq;

    initial begin
        cnt = 64'd0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 32'h1234);

        // Reset state
        check("rst_irq", {63'd0, irq}, 64'd0);
        check("rst_rdata", {32'd0, rdata}, 64'd0);
        rd_reg(3'd5);
        check("rst_ctrl", {32'd0, rdata}, 64'd0);
        rd_reg(3'd3);
        check("rst_cmp_hi", {32'd0, rdata}, 64'h0000_0000_FFFF_FFFF);

        // Tear-free count read: HI comes from the snapshot, not the live count
        cnt = 64'h0000_0001_FFFF_FFFF;
        rd_reg(3'd0);
        check("atomic_lo", {32'd0, rdata}, 64'h0000_0000_FFFF_FFFF);
        cnt = 64'h0000_0002_0000_0005;
        rd_reg(3'd1);
        check("atomic_hi", {32'd0, rdata}, 64'd1);

        // One-shot
        cnt = 64'd90;
        wr_reg(3'd2, 32'd100);
        wr_reg(3'd3, 32'd0);
        wr_reg(3'd4, 32'd0);
        wr_reg(3'd5, 32'd3);
        while (cnt < 64'd100) begin
            cnt++;
            idle();
        end
        check("oneshot_irq", {63'd0, irq}, 64'd1);
        rd_reg(3'd5);
        check("oneshot_ctrl", {32'd0, rdata}, 64'd2);
        wr_reg(3'd6, 32'd1);
        check("oneshot_clr", {63'd0, irq}, 64'd0);

        // Periodic: hits at 50, 60, 70 leave cmp at 80
        wr_reg(3'd2, 32'd50);
        wr_reg(3'd4, 32'd10);
        cnt = 64'd40;
        wr_reg(3'd5, 32'd3);
        n_rise = 0;
        prev_irq = 1'b0;
        while (cnt < 64'd75) begin
            cnt++;
            if (irq) wr_reg(3'd6, 32'd1);
            else     idle();
            if (irq && !prev_irq) n_rise++;
            prev_irq = irq;
        end
        check("periodic_hits", 64'(n_rise), 64'd3);
        rd_reg(3'd2);
        check("periodic_cmp", {32'd0, rdata}, 64'd80);

        // Collisions
        cnt = 64'd79;
        idle();
        cnt = 64'd80;
        wr_reg(3'd6, 32'd1);
        check("w1c_vs_hit", {63'd0, irq}, 64'd1);
        cnt = 64'd90;
        wr_reg(3'd2, 32'd200);
        cnt = 64'd91;
        rd_reg(3'd2);
        check("sw_cmp_wins", {32'd0, rdata}, 64'd200);
        wr_reg(3'd6, 32'd1);

        // Wrap of the 64-bit reload add
        wr_reg(3'd5, 32'd0);
        wr_reg(3'd2, 32'hFFFF_FFFB);
        wr_reg(3'd3, 32'hFFFF_FFFF);
        cnt = 64'hFFFF_FFFF_FFFF_FFFC;
        wr_reg(3'd5, 32'd1);
        idle();
        cnt = 64'd0;
        rd_reg(3'd2);
        check("wrap_lo", {32'd0, rdata}, 64'd5);
        rd_reg(3'd3);
        check("wrap_hi", {32'd0, rdata}, 64'd0);

        // Reset during an in-flight write
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 32'h55);
        rd_reg(3'd2);
        check("midrst_cmp", {32'd0, rdata}, 64'h0000_0000_FFFF_FFFF);
        rd_reg(3'd4);
        check("midrst_period", {32'd0, rdata}, 64'd0);

        // Randomized traffic, including catch-up after count jumps
        cnt = 64'h0000_0003_FFFF_FF00;
        for (int i = 0; i < 4000; i++) begin
            int op;
            logic [2:0] ra;
            op = int'($urandom_range(0, 19));
            ra = 3'($urandom);
            if ($urandom_range(0, 63) == 0) cnt = cnt + 64'($urandom_range(20, 120));
            else                            cnt = cnt + 64'($urandom_range(0, 3));
            if ($urandom_range(0, 999) == 0) begin
                step(1'b1, 1'b1, 1'b1, 1'($urandom), ra, $urandom);
            end else begin
                case (op)
                    0, 1, 2, 3:  idle();
                    4, 5, 6, 7:  rd_reg(ra);
                    8:  wr_reg(3'd2, cnt[31:0] + 32'($urandom_range(0, 40)));
                    9:  wr_reg(3'd3, cnt[63:32] + 32'($urandom_range(0, 1)));
                    10: wr_reg(3'd4, 32'($urandom_range(0, 8)));
                    11, 12: wr_reg(3'd5, 32'($urandom_range(0, 3)) | ($urandom & 32'hFFFF_FFFC));
                    13: wr_reg(3'd6, $urandom);
                    14: step(1'b0, 1'b1, 1'b1, 1'b1, ra, $urandom);
                    15: step(1'b0, 1'b0, 1'b1, 1'($urandom), ra, $urandom);
                    16: wr_reg(ra, $urandom);
                    default: begin
                        wr_reg(3'd2, cnt[31:0] + 32'($urandom_range(0, 10)));
                        wr_reg(3'd3, cnt[63:32]);
                        wr_reg(3'd5, 32'd3);
                    end
                endcase
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
